// File: rtl/box_window_sched_pkg.sv
// box_pkg: shared state encoding and dimension constants for the window scheduler
package box_pkg;
  localparam int PIX_W = 8;
  localparam int DEF_WIDTH = 512;
  localparam int DEF_HEIGHT = 512;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;
endpackage

// File: rtl/box_window_sched_if.sv
// box_window_sched_if: pixel stream in, window triple out, frame control
interface box_window_sched_if import box_pkg::*; ;
  logic i_start;
  logic [PIX_W-1:0] i_pixel;
  logic i_pixel_valid;
  logic o_pixel_ack;
  logic [PIX_W-1:0] o_pixel_1;
  logic [PIX_W-1:0] o_pixel_2;
  logic [PIX_W-1:0] o_pixel_3;
  logic o_win_valid;
  logic i_win_ack;
  logic o_busy;
  logic o_frame_done;
  modport slave (
    input i_start, i_pixel, i_pixel_valid, i_win_ack,
    output o_pixel_ack, o_pixel_1, o_pixel_2, o_pixel_3, o_win_valid, o_busy, o_frame_done
  );
  modport master (
    output i_start, i_pixel, i_pixel_valid, i_win_ack,
    input o_pixel_ack, o_pixel_1, o_pixel_2, o_pixel_3, o_win_valid, o_busy, o_frame_done
  );
endinterface

// File: rtl/box_window_sched_line_buf_ram.sv
// line_buf_ram: single-port line buffer with synchronous read-first output register
module line_buf_ram import box_pkg::*; #(
  parameter int DEPTH = DEF_WIDTH
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic en,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem [DEPTH];
  // array write; contents are refilled every frame so they carry no reset
  always_ff @(posedge i_clk)
    if (en && we) mem[addr] <= wdata;
  // read-first: the registered output sees the value before this cycle's write
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) rdata <= '0;
    else if (en) rdata <= mem[addr];
endmodule

// File: rtl/box_window_sched.sv
// box_window_sched: buffers two lines and issues vertically aligned pixel triples
module box_window_sched import box_pkg::*; #(
  parameter int IMG_WIDTH = DEF_WIDTH,
  parameter int IMG_HEIGHT = DEF_HEIGHT
) (
  input logic i_clk,
  input logic i_rst_n,
  box_window_sched_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  state_t state, state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic accept, run_acc, last_col, sel_q;
  logic [PIX_W-1:0] a_rd, b_rd;
  assign last_col = col == CW'(IMG_WIDTH - 1);
  assign bus.o_pixel_ack = state == PRIME || (state == RUN && (!bus.o_win_valid || bus.i_win_ack));
  assign accept = bus.o_pixel_ack && bus.i_pixel_valid;
  assign run_acc = accept && state == RUN;
  assign bus.o_busy = state != IDLE;
  assign bus.o_frame_done = state == DONE && !bus.o_win_valid;
  // the two buffers alternate by row parity, so the one being overwritten always holds row y-2
  assign bus.o_pixel_2 = sel_q ? a_rd : b_rd;
  assign bus.o_pixel_3 = sel_q ? b_rd : a_rd;
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  // frame sequencing: prime two lines, stream the rest, drain the last triple
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.i_start) state_nx = PRIME;
      PRIME: if (accept && last_col && row == RW'(1)) state_nx = RUN;
      RUN:   if (accept && last_col && row == RW'(IMG_HEIGHT - 1)) state_nx = DONE;
      DONE:  if (!bus.o_win_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // raster position of the next pixel; held at zero while idle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= last_col ? '0 : col + 1'b1;
      row <= last_col ? row + 1'b1 : row;
    end
  // window output register; the buffer outputs only move on an accepted pixel
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      bus.o_win_valid <= 1'b0;
      bus.o_pixel_1 <= '0;
      sel_q <= 1'b0;
    end else begin
      bus.o_win_valid <= run_acc || (bus.o_win_valid && !bus.i_win_ack);
      if (run_acc) begin
        bus.o_pixel_1 <= bus.i_pixel;
        sel_q <= row[0];
      end
    end
  line_buf_ram #(.DEPTH(IMG_WIDTH)) u_buf_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .en(accept), .we(accept && !row[0]),
    .addr(col), .wdata(bus.i_pixel), .rdata(a_rd)
  );
  line_buf_ram #(.DEPTH(IMG_WIDTH)) u_buf_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .en(accept), .we(accept && row[0]),
    .addr(col), .wdata(bus.i_pixel), .rdata(b_rd)
  );
endmodule

// File: tb/tb_box_window_sched.sv
// tb_box_window_sched: directed frames on a 4x4 image with ramp pixels
module tb_box_window_sched;
  localparam int W = 4;
  localparam int H = 4;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int ncmp = 0;
  int nerr = 0;
  int base, sent, ntri, ndone, scnt, cyc, last_tri;
  box_window_sched_if bus ();
  box_window_sched #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] exp_tri(input int b, input int k);
    int y, x;
    y = 2 + k / W;
    x = k % W;
    return {8'(b + W * y + x), 8'(b + W * (y - 1) + x), 8'(b + W * (y - 2) + x)};
  endfunction
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ack"}, 32'(bus.o_pixel_ack), 0);
    chk({tag, "_valid"}, 32'(bus.o_win_valid), 0);
    chk({tag, "_pix"}, {8'd0, bus.o_pixel_1, bus.o_pixel_2, bus.o_pixel_3}, 0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 0);
    chk({tag, "_done"}, 32'(bus.o_frame_done), 0);
  endtask
  task automatic tick();
    @(negedge i_clk);
    cyc++;
    if (bus.o_win_valid && bus.i_win_ack) begin
      chk("triple", {8'd0, bus.o_pixel_1, bus.o_pixel_2, bus.o_pixel_3}, 32'(exp_tri(base, ntri)));
      last_tri = cyc;
      ntri++;
    end
    if (bus.o_win_valid && !bus.i_win_ack) begin
      chk("stall_ack", 32'(bus.o_pixel_ack), 0);
      chk("stall_triple", {8'd0, bus.o_pixel_1, bus.o_pixel_2, bus.o_pixel_3}, 32'(exp_tri(base, ntri)));
      scnt++;
    end
    if (sent < 9) chk("prime_valid", 32'(bus.o_win_valid), 0);
    if (bus.o_frame_done) begin
      chk("done_lag", 32'(cyc - last_tri), 1);
      ndone++;
    end
    if (bus.i_start && sent > 0) chk("busy_on_start", 32'(bus.o_busy), 1);
    if (bus.i_pixel_valid && bus.o_pixel_ack) sent++;
    @(posedge i_clk);
    #1;
  endtask
  task automatic frame(input int b, input bit bub, input bit stall, input bit smid, input int npix);
    base = b;
    sent = 0;
    ntri = 0;
    ndone = 0;
    scnt = 0;
    last_tri = -100;
    bus.i_start = 1'b1;
    bus.i_pixel_valid = 1'b0;
    bus.i_win_ack = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int c = 0; c < 300 && ndone == 0 && !(npix < W * H && sent == npix); c++) begin
      bus.i_pixel = 8'(b + sent);
      bus.i_pixel_valid = sent < npix && (!bub || c[0]);
      bus.i_win_ack = !(stall && ntri == 2 && bus.o_win_valid && scnt < 5);
      bus.i_start = smid && ntri == 3;
      tick();
    end
    bus.i_pixel_valid = 1'b0;
    bus.i_start = 1'b0;
    bus.i_win_ack = 1'b1;
  endtask
  task automatic frame_ok(input string tag);
    chk({tag, "_triples"}, 32'(ntri), W * (H - 2));
    chk({tag, "_pixels"}, 32'(sent), W * H);
    chk({tag, "_done"}, 32'(ndone), 1);
    for (int i = 0; i < 3; i++) tick();
    chk({tag, "_single_done"}, 32'(ndone), 1);
    chk({tag, "_idle"}, 32'(bus.o_busy), 0);
  endtask
  initial begin
    bus.i_start = 1'b0;
    bus.i_pixel = '0;
    bus.i_pixel_valid = 1'b0;
    bus.i_win_ack = 1'b1;
    cyc = 0;
    sent = 16;
    ndone = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk_reset_outs("reset");
    i_rst_n = 1'b1;
    tick();
    chk_reset_outs("idle");
    frame(0, 1'b0, 1'b0, 1'b0, 16);
    frame_ok("basic");
    frame(0, 1'b0, 1'b1, 1'b0, 16);
    chk("stall_cycles", 32'(scnt), 5);
    frame_ok("backpressure");
    frame(0, 1'b1, 1'b0, 1'b0, 16);
    frame_ok("bubbly");
    frame(0, 1'b0, 1'b0, 1'b1, 16);
    frame_ok("start_in_run");
    frame(100, 1'b0, 1'b0, 1'b0, 16);
    frame_ok("second_frame");
    frame(0, 1'b0, 1'b0, 1'b0, 10);
    chk("abort_pixels", 32'(sent), 10);
    chk("abort_valid", 32'(bus.o_win_valid), 1);
    chk("abort_triple", {8'd0, bus.o_pixel_1, bus.o_pixel_2, bus.o_pixel_3}, 32'h00090501);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk_reset_outs("async_reset");
    tick();
    tick();
    chk("abort_no_done", 32'(ndone), 0);
    chk_reset_outs("held_reset");
    i_rst_n = 1'b1;
    tick();
    frame(0, 1'b0, 1'b0, 1'b0, 16);
    frame_ok("after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
